// File: rtl/toe_conn_table.sv
// TCP-offload connection table: holds DEPTH 6-tuples and resolves LOOKUP/INSERT/DELETE/CLEAR
// requests with a sequential scan that examines one entry per enabled cycle.
`timescale 1ns/1ps

module toe_conn_table #(
  parameter int DEPTH  = 16,
  parameter int ID_W   = $clog2(DEPTH),
  parameter int MAC_W  = 48,
  parameter int IP_W   = 32,
  parameter int PORT_W = 16
) (
  input  logic              clk,
  input  logic              RESET_n,
  input  logic              ENABLE,
  input  logic              REQ_NEW,
  input  logic [1:0]        OP,
  input  logic [MAC_W-1:0]  src_mac,
  input  logic [MAC_W-1:0]  dst_mac,
  input  logic [IP_W-1:0]   src_ip,
  input  logic [IP_W-1:0]   dst_ip,
  input  logic [PORT_W-1:0] src_port,
  input  logic [PORT_W-1:0] dst_port,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [1:0]        ERR_CODE,
  output logic [ID_W-1:0]   ID,
  output logic [ID_W:0]     COUNT
);

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_MISS = 2'd1;
  localparam logic [1:0] ERR_DUP  = 2'd2;
  localparam logic [1:0] ERR_FULL = 2'd3;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t state;
  logic [1:0] op_q;

  logic [MAC_W-1:0]  key_src_mac, key_dst_mac;
  logic [IP_W-1:0]   key_src_ip, key_dst_ip;
  logic [PORT_W-1:0] key_src_port, key_dst_port;

  logic [MAC_W-1:0]  tab_src_mac  [DEPTH];
  logic [MAC_W-1:0]  tab_dst_mac  [DEPTH];
  logic [IP_W-1:0]   tab_src_ip   [DEPTH];
  logic [IP_W-1:0]   tab_dst_ip   [DEPTH];
  logic [PORT_W-1:0] tab_src_port [DEPTH];
  logic [PORT_W-1:0] tab_dst_port [DEPTH];
  logic [DEPTH-1:0]  valid;

  logic [ID_W-1:0] idx, hit_idx, free_idx;
  logic            hit, free_found;
  logic            entry_match, last_entry;

  assign entry_match = valid[idx] &&
                       (tab_src_mac[idx]  == key_src_mac)  && (tab_dst_mac[idx]  == key_dst_mac) &&
                       (tab_src_ip[idx]   == key_src_ip)   && (tab_dst_ip[idx]   == key_dst_ip)  &&
                       (tab_src_port[idx] == key_src_port) && (tab_dst_port[idx] == key_dst_port);
  assign last_entry  = (idx == ID_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!RESET_n) begin
      state      <= IDLE;
      op_q       <= OP_LOOKUP;
      valid      <= '0;
      idx        <= '0;
      hit        <= 1'b0;
      hit_idx    <= '0;
      free_found <= 1'b0;
      free_idx   <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      ERR_CODE   <= ERR_NONE;
      ID         <= '0;
      COUNT      <= '0;
    end else begin
      // DONE/ERROR are single-cycle pulses; everything else freezes while ENABLE is low
      DONE  <= 1'b0;
      ERROR <= 1'b0;
      if (ENABLE) begin
        case (state)
          IDLE: begin
            BUSY <= 1'b0;
            if (REQ_NEW && !BUSY) begin
              op_q         <= OP;
              key_src_mac  <= src_mac;
              key_dst_mac  <= dst_mac;
              key_src_ip   <= src_ip;
              key_dst_ip   <= dst_ip;
              key_src_port <= src_port;
              key_dst_port <= dst_port;
              idx          <= '0;
              hit          <= 1'b0;
              free_found   <= 1'b0;
              BUSY         <= 1'b1;
              state        <= (OP == OP_CLEAR) ? RESP : SCAN;
            end
          end
          SCAN: begin
            if (entry_match && !hit) begin
              hit     <= 1'b1;
              hit_idx <= idx;
            end
            if (!valid[idx] && !free_found) begin
              free_found <= 1'b1;
              free_idx   <= idx;
            end
            // INSERT must see every entry to rule out a duplicate; the others stop on first hit
            if ((op_q != OP_INSERT && entry_match) || last_entry) state <= RESP;
            else idx <= idx + 1'b1;
          end
          RESP: begin
            state <= IDLE;
            DONE  <= 1'b1;
            case (op_q)
              OP_CLEAR: begin
                valid    <= '0;
                COUNT    <= '0;
                ERR_CODE <= ERR_NONE;
                ID       <= '0;
              end
              OP_INSERT: begin
                if (hit) begin
                  ERROR    <= 1'b1;
                  ERR_CODE <= ERR_DUP;
                  ID       <= hit_idx;
                end else if (!free_found) begin
                  ERROR    <= 1'b1;
                  ERR_CODE <= ERR_FULL;
                end else begin
                  tab_src_mac[free_idx]  <= key_src_mac;
                  tab_dst_mac[free_idx]  <= key_dst_mac;
                  tab_src_ip[free_idx]   <= key_src_ip;
                  tab_dst_ip[free_idx]   <= key_dst_ip;
                  tab_src_port[free_idx] <= key_src_port;
                  tab_dst_port[free_idx] <= key_dst_port;
                  valid[free_idx]        <= 1'b1;
                  COUNT                  <= COUNT + 1'b1;
                  ERR_CODE               <= ERR_NONE;
                  ID                     <= free_idx;
                end
              end
              default: begin
                if (hit) begin
                  ERR_CODE <= ERR_NONE;
                  ID       <= hit_idx;
                  if (op_q == OP_DELETE) begin
                    valid[hit_idx] <= 1'b0;
                    COUNT          <= COUNT - 1'b1;
                  end
                end else begin
                  ERROR    <= 1'b1;
                  ERR_CODE <= ERR_MISS;
                end
              end
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
